// File: rtl/memory_port_arbiter_if.sv
// Requester-side port of the memory arbiter: request, transfer
// attributes, completion pulse and returned read data.
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [0:ADDR_WIDTH-1] address;
    logic [0:DATA_WIDTH-1] data_in;
    logic                  ack;
    logic [0:DATA_WIDTH-1] data_out;

    modport master (
        output req, we, lock, address, data_in,
        input  ack, data_out
    );

    modport slave (
        input  req, we, lock, address, data_in,
        output ack, data_out
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between CPU and IOP.
// Ports: clock/reset, cpu/iop requester ports, registered mem_* bus, owner, busy.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_port_arbiter_if.slave  cpu,
    memory_port_arbiter_if.slave  iop,
    output logic [0:ADDR_WIDTH-1] mem_address,
    output logic                  mem_write_en,
    output logic [0:DATA_WIDTH-1] mem_data_out,
    input  logic [0:DATA_WIDTH-1] mem_data_in,
    output logic                  owner,
    output logic                  busy
);

    localparam logic [3:0] LOCK_CAP = 4'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  locked;
    logic                  lock_at_grant;
    logic [3:0]            lock_count;
    logic                  cpu_ack_q;
    logic                  iop_ack_q;
    logic [0:DATA_WIDTH-1] cpu_data_q;
    logic [0:DATA_WIDTH-1] iop_data_q;

    logic both_req;
    logic any_req;
    logic hold;
    logic force_switch;
    logic grant_iop;

    assign cpu.ack      = cpu_ack_q;
    assign iop.ack      = iop_ack_q;
    assign cpu.data_out = cpu_data_q;
    assign iop.data_out = iop_data_q;

    // A locked owner keeps the port under contention until its
    // lock budget is spent; then the waiting master is forced in.
    always_comb begin
        both_req     = cpu.req & iop.req;
        any_req      = cpu.req | iop.req;
        hold         = locked & (lock_count < LOCK_CAP);
        force_switch = both_req & locked & ~hold;
        grant_iop    = 1'b0;
        unique case (1'b1)
            (cpu.req & ~iop.req): grant_iop = 1'b0;
            (iop.req & ~cpu.req): grant_iop = 1'b1;
            (both_req & hold):    grant_iop = owner;
            (both_req & ~hold):   grant_iop = ~last_grant;
            default:              grant_iop = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem_address   <= '0;
            mem_write_en  <= 1'b0;
            mem_data_out  <= '0;
            owner         <= 1'b0;
            busy          <= 1'b0;
            last_grant    <= 1'b1;
            locked        <= 1'b0;
            lock_at_grant <= 1'b0;
            lock_count    <= '0;
            cpu_ack_q     <= 1'b0;
            iop_ack_q     <= 1'b0;
            cpu_data_q    <= '0;
            iop_data_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= ACCESS;
                        busy          <= 1'b1;
                        owner         <= grant_iop;
                        mem_address   <= grant_iop ? iop.address : cpu.address;
                        mem_data_out  <= grant_iop ? iop.data_in : cpu.data_in;
                        mem_write_en  <= grant_iop ? iop.we : cpu.we;
                        lock_at_grant <= grant_iop ? iop.lock : cpu.lock;
                        if (force_switch) begin
                            locked     <= 1'b0;
                            lock_count <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state        <= DONE;
                    mem_write_en <= 1'b0;
                    // Memory read data is combinational; sample it at
                    // the edge that ends the access cycle.
                    if (!mem_write_en) begin
                        if (owner) iop_data_q <= mem_data_in;
                        else       cpu_data_q <= mem_data_in;
                    end
                    if (owner) iop_ack_q <= 1'b1;
                    else       cpu_ack_q <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cpu_ack_q  <= 1'b0;
                    iop_ack_q  <= 1'b0;
                    last_grant <= owner;
                    // The lock run restarts whenever ownership changes.
                    if (lock_at_grant) begin
                        locked <= 1'b1;
                        if (locked && (owner == last_grant)) begin
                            if (lock_count != 4'hF)
                                lock_count <= lock_count + 4'd1;
                        end else begin
                            lock_count <= 4'd1;
                        end
                    end else begin
                        locked     <= 1'b0;
                        lock_count <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    mem_write_en <= 1'b0;
                    cpu_ack_q    <= 1'b0;
                    iop_ack_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a behavioural word memory.
// Ports: drives both requester interfaces, models memory, checks outputs.
module tb_memory_port_arbiter;

    logic        clock;
    logic        reset;
    logic [0:16] mem_address;
    logic        mem_write_en;
    logic [0:31] mem_data_out;
    logic [0:31] mem_data_in;
    logic        owner;
    logic        busy;

    logic [0:31] mem [0:131071];
    logic        pl_en;
    logic [0:16] pl_addr;
    logic [0:31] pl_data;

    int checks;
    int errors;
    int idle_cnt;
    int viol;
    int we_cycles;

    memory_port_arbiter_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) cpu_if ();
    memory_port_arbiter_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) iop_if ();

    memory_port_arbiter #(
        .ADDR_WIDTH(17),
        .DATA_WIDTH(32),
        .LOCK_MAX(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu(cpu_if),
        .iop(iop_if),
        .mem_address(mem_address),
        .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in),
        .owner(owner),
        .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign mem_data_in = mem[mem_address];

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_write_en) mem[mem_address] <= mem_data_out;
    end

    initial begin
        viol = 0;
        we_cycles = 0;
    end

    always @(posedge clock) begin
        if (cpu_if.ack && iop_if.ack) viol++;
        if (mem_write_en && (!busy || cpu_if.ack || iop_if.ack)) viol++;
        if (mem_write_en) we_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [16:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en = 1'b1;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic wait_ack(output logic who, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (!busy) idle_cnt++;
        end while (!(cpu_if.ack || iop_if.ack) && cyc < 12);
        who = iop_if.ack;
        if (!(cpu_if.ack || iop_if.ack)) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    logic who;
    int   cyc;

    initial begin
        checks = 0;
        errors = 0;
        idle_cnt = 0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        cpu_if.req = 1'b0;
        cpu_if.we = 1'b0;
        cpu_if.lock = 1'b0;
        cpu_if.address = '0;
        cpu_if.data_in = '0;
        iop_if.req = 1'b0;
        iop_if.we = 1'b0;
        iop_if.lock = 1'b0;
        iop_if.address = '0;
        iop_if.data_in = '0;
        reset = 1'b1;
        #1 reset = 1'b0;

        preload(17'h00010, 32'hDEADBEEF);
        preload(17'h00020, 32'h12345678);
        for (int i = 0; i < 8; i++)
            preload(17'h00200 + 17'(i), 32'hA5000000 + 32'(i));

        check("rst_we", 32'(mem_write_en), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", mem_data_out, 32'd0);
        check("rst_cpu_ack", 32'(cpu_if.ack), 32'd0);
        check("rst_iop_ack", 32'(iop_if.ack), 32'd0);
        check("rst_cpu_dout", cpu_if.data_out, 32'd0);
        check("rst_iop_dout", iop_if.data_out, 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // CPU read of preloaded word
        cpu_if.req = 1'b1;
        cpu_if.address = 17'h00010;
        wait_ack(who, cyc);
        check("rd_who", 32'(who), 32'd0);
        check("rd_latency", 32'(cyc), 32'd2);
        check("rd_data", cpu_if.data_out, 32'hDEADBEEF);
        check("rd_iop_ack", 32'(iop_if.ack), 32'd0);
        cpu_if.req = 1'b0;
        @(negedge clock);
        check("rd_ack_pulse", 32'(cpu_if.ack), 32'd0);
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_hold", cpu_if.data_out, 32'hDEADBEEF);

        // IOP write then CPU read-back
        iop_if.req = 1'b1;
        iop_if.we = 1'b1;
        iop_if.address = 17'h00100;
        iop_if.data_in = 32'h00010001;
        @(negedge clock);
        check("wr_we", 32'(mem_write_en), 32'd1);
        check("wr_addr", 32'(mem_address), 32'h100);
        check("wr_wdata", mem_data_out, 32'h00010001);
        check("wr_owner", 32'(owner), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("wr_ack", 32'(iop_if.ack), 32'd1);
        check("wr_we_done", 32'(mem_write_en), 32'd0);
        check("wr_cpu_ack", 32'(cpu_if.ack), 32'd0);
        check("wr_mem", mem[17'h00100], 32'h00010001);
        iop_if.req = 1'b0;
        iop_if.we = 1'b0;
        cpu_if.req = 1'b1;
        cpu_if.address = 17'h00100;
        wait_ack(who, cyc);
        check("rb_who", 32'(who), 32'd0);
        check("rb_data", cpu_if.data_out, 32'h00010001);
        check("rb_we_cycles", 32'(we_cycles), 32'd1);
        cpu_if.req = 1'b0;
        @(negedge clock);

        // Contended round-robin from reset
        pulse_reset();
        cpu_if.req = 1'b1;
        cpu_if.address = 17'h00010;
        iop_if.req = 1'b1;
        iop_if.address = 17'h00020;
        for (int i = 0; i < 6; i++) begin
            wait_ack(who, cyc);
            check("rr_who", 32'(who), 32'(i % 2));
            check("rr_spacing", 32'(cyc), (i == 0) ? 32'd2 : 32'd3);
            if (who) check("rr_iop_data", iop_if.data_out, 32'h12345678);
            else     check("rr_cpu_data", cpu_if.data_out, 32'hDEADBEEF);
        end
        cpu_if.req = 1'b0;
        iop_if.req = 1'b0;
        @(negedge clock);

        // Lock bound under contention, then uncontended lock run
        pulse_reset();
        cpu_if.req = 1'b1;
        cpu_if.lock = 1'b1;
        cpu_if.address = 17'h00010;
        iop_if.req = 1'b1;
        iop_if.address = 17'h00020;
        for (int i = 0; i < 5; i++) begin
            wait_ack(who, cyc);
            check("lk_who", 32'(who), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) iop_if.req = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            wait_ack(who, cyc);
            check("lk_solo_who", 32'(who), 32'd0);
            check("lk_solo_spacing", 32'(cyc), 32'd3);
            check("lk_solo_owner", 32'(owner), 32'd0);
        end
        cpu_if.req = 1'b0;
        cpu_if.lock = 1'b0;
        @(negedge clock);

        // Reset in the middle of an IOP write
        pulse_reset();
        iop_if.req = 1'b1;
        iop_if.we = 1'b1;
        iop_if.address = 17'h00020;
        iop_if.data_in = 32'hCAFEF00D;
        @(negedge clock);
        check("ra_we_before", 32'(mem_write_en), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("ra_we_drop", 32'(mem_write_en), 32'd0);
        check("ra_busy", 32'(busy), 32'd0);
        iop_if.req = 1'b0;
        iop_if.we = 1'b0;
        @(negedge clock);
        check("ra_mem", mem[17'h00020], 32'h12345678);
        check("ra_no_ack", 32'(iop_if.ack), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("ra_idle_ack", 32'(iop_if.ack | cpu_if.ack), 32'd0);
        check("ra_idle_busy", 32'(busy), 32'd0);

        // Single-master back-to-back stream
        idle_cnt = 0;
        cpu_if.req = 1'b1;
        cpu_if.address = 17'h00200;
        for (int i = 0; i < 8; i++) begin
            wait_ack(who, cyc);
            check("st_who", 32'(who), 32'd0);
            check("st_spacing", 32'(cyc), (i == 0) ? 32'd2 : 32'd3);
            check("st_data", cpu_if.data_out, 32'hA5000000 + 32'(i));
            check("st_owner", 32'(owner), 32'd0);
            cpu_if.address = 17'h00201 + 17'(i);
        end
        cpu_if.req = 1'b0;
        check("st_idle_cycles", 32'(idle_cnt), 32'd7);
        @(negedge clock);
        @(negedge clock);
        check("bus_invariants", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
